// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - instruction fetch queue: PC generation, req/gnt bus issue, in-order response buffering, flush on jump
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   jump_flag_i, jump_addr_i  one-cycle flush and redirect target
//   ibus_req_o, ibus_addr_o   fetch request and word-aligned fetch address
//   ibus_gnt_i                request accepted this cycle
//   ibus_rvld_i, ibus_data_i  in-order response valid and instruction word
//   inst_vld_o, inst_rdy_i    head entry handshake toward the decoder
//   inst_data_o, inst_addr_o  head instruction and its PC
module ifu_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvld_i,
    input  logic [DATA_W-1:0] ibus_data_i,
    output logic              inst_vld_o,
    input  logic              inst_rdy_i,
    output logic [DATA_W-1:0] inst_data_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_fill_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_res_cnt;    // slots reserved or filled
    logic [CNT_W-1:0]  r_pend_cnt;   // reserved, response not yet arrived
    logic [CNT_W-1:0]  r_discard;    // stale responses still to be dropped
    logic [ADDR_W-1:0] r_slot_addr [DEPTH];
    logic [DATA_W-1:0] r_slot_data [DEPTH];
    logic [DEPTH-1:0]  r_slot_full;

    logic [CNT_W:0]    w_occ;
    logic              w_req;
    logic              w_grant;
    logic              w_drop;
    logic              w_fill;
    logic              w_head_vld;
    logic              w_pop;
    logic              w_old_rsp;
    logic [CNT_W-1:0]  w_jump_discard;
    logic [ADDR_W-1:0] w_jump_pc;

    // Stale responses still occupy bus capacity, so they count against DEPTH.
    assign w_occ      = {1'b0, r_res_cnt} + {1'b0, r_discard};
    assign w_req      = rst_n_i & ~jump_flag_i & (w_occ < (CNT_W + 1)'(DEPTH));
    assign w_grant    = w_req & ibus_gnt_i;
    assign w_drop     = ibus_rvld_i & (r_discard != '0);
    assign w_fill     = ibus_rvld_i & (r_discard == '0) & (r_pend_cnt != '0);
    assign w_head_vld = r_slot_full[r_rd_ptr];
    assign w_pop      = w_head_vld & inst_rdy_i & ~jump_flag_i;

    // On a flush every unfilled reservation becomes a stale response; a response
    // arriving in the flush cycle itself is already accounted for and consumed.
    assign w_old_rsp      = ibus_rvld_i & ((r_discard != '0) | (r_pend_cnt != '0));
    assign w_jump_discard = r_discard + r_pend_cnt - CNT_W'(w_old_rsp);
    assign w_jump_pc      = jump_addr_i & ~ADDR_W'(3);

    assign ibus_req_o  = w_req;
    assign ibus_addr_o = r_pc;
    assign inst_vld_o  = w_head_vld;
    assign inst_data_o = r_slot_data[r_rd_ptr];
    assign inst_addr_o = r_slot_addr[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc        <= RESET_PC;
            r_wr_ptr    <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_res_cnt   <= '0;
            r_pend_cnt  <= '0;
            r_discard   <= '0;
            r_slot_full <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_addr[i] <= '0;
                r_slot_data[i] <= '0;
            end
        end else if (jump_flag_i) begin
            r_pc        <= w_jump_pc;
            r_wr_ptr    <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_res_cnt   <= '0;
            r_pend_cnt  <= '0;
            r_discard   <= w_jump_discard;
            r_slot_full <= '0;
        end else begin
            if (w_grant) begin
                r_pc                  <= r_pc + ADDR_W'(4);
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                r_slot_addr[r_wr_ptr] <= r_pc;
            end
            if (w_fill) begin
                r_fill_ptr              <= r_fill_ptr + PTR_W'(1);
                r_slot_data[r_fill_ptr] <= ibus_data_i;
                r_slot_full[r_fill_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
                r_slot_full[r_rd_ptr] <= 1'b0;
            end
            r_res_cnt  <= r_res_cnt + CNT_W'(w_grant) - CNT_W'(w_pop);
            r_pend_cnt <= r_pend_cnt + CNT_W'(w_grant) - CNT_W'(w_fill);
            r_discard  <= r_discard - CNT_W'(w_drop);
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_rvld: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(ibus_rvld_i && r_discard == '0 && r_pend_cnt == '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (w_occ <= (CNT_W + 1)'(DEPTH)));
`endif

endmodule
